dmem_responder: RTL and testbench

- Data-memory target for the pipelined RISC-V core. It services load and store requests over a valid/ready request channel and a valid/ready response channel.
- It is the responder side of the core's MEM-stage interface and replaces the zero-latency RAM with a handshaked memory.
- It has configurable wait states, byte/halfword/word access by funct3, little-endian layout and error signalling for misaligned, illegal or out-of-range accesses.

---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Request/response channel between MEM stage and data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Handshaked data memory with wait states, sized access and errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_busy;
  logic        w_commit;
  logic        w_accept;

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_oor;
  logic        w_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The counter is loaded on acceptance and the access commits on the edge
  // after it has drained to zero, giving 1+WAIT_CYCLES cycles to response.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_commit    = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (bus.req_valid) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept      = (r_state == ST_IDLE) && bus.req_valid;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign busy          = w_busy;

  // Access decode works on the latched request only.
  assign w_f3_ok    = r_we ? (r_funct3 == 3'b000 || r_funct3 == 3'b001 || r_funct3 == 3'b010)
                           : (r_funct3 == 3'b000 || r_funct3 == 3'b001 || r_funct3 == 3'b010 ||
                              r_funct3 == 3'b100 || r_funct3 == 3'b101);
  assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                      ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_oor      = |r_addr[31:ADDR_WIDTH+2];
  assign w_err      = !w_f3_ok || w_misalign || w_oor;
  assign w_idx      = r_addr[ADDR_WIDTH+1:2];
  assign w_word     = r_mem[w_idx];
  assign w_half     = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    w_load = 32'd0;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wlane = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_funct3 <= 3'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= c_wait_init;
        r_we     <= bus.req_we;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_funct3 <= bus.req_funct3;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
        r_err   <= w_err;
      end
    end
  end

  // Storage is deliberately not reset; commit is gated by state, so a reset
  // during WAIT can never reach the array.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed checks of dmem_responder with 2 and 0 wait states.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam bit D2 = 1'b0;
  localparam bit D0 = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy2, busy0;
  logic        v2, v0, rwe, rrdy;
  logic [31:0] raddr, rwdata;
  logic [2:0]  rf3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder_if if2();
  dmem_responder_if if0();

  assign if2.req_valid  = v2;
  assign if2.req_we     = rwe;
  assign if2.req_addr   = raddr;
  assign if2.req_wdata  = rwdata;
  assign if2.req_funct3 = rf3;
  assign if2.rsp_ready  = rrdy;
  assign if0.req_valid  = v0;
  assign if0.req_we     = rwe;
  assign if0.req_addr   = raddr;
  assign if0.req_wdata  = rwdata;
  assign if0.req_funct3 = rf3;
  assign if0.rsp_ready  = rrdy;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .busy(busy2)
  );
  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic valid_of(input bit s);
    return s ? if0.rsp_valid : if2.rsp_valid;
  endfunction
  function automatic logic [31:0] rdata_of(input bit s);
    return s ? if0.rsp_rdata : if2.rsp_rdata;
  endfunction
  function automatic logic err_of(input bit s);
    return s ? if0.rsp_err : if2.rsp_err;
  endfunction

  task automatic issue(input bit s, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    @(negedge clk);
    rwe = we; raddr = a; rwdata = wd; rf3 = f3;
    if (s) v0 = 1'b1; else v2 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v2 = 1'b0;
  endtask

  task automatic collect(input bit s, output logic [31:0] rd, output logic err, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (valid_of(s)) break;
      @(posedge clk);
      lat++;
    end
    check("rsp_valid seen", {31'd0, valid_of(s)}, 32'd1);
    rd  = rdata_of(s);
    err = err_of(s);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, output logic [31:0] rd, output logic err, output int lat);
    issue(s, we, a, wd, f3);
    collect(s, rd, err, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    rst_n = 1'b0; v2 = 1'b0; v0 = 1'b0; rwe = 1'b0;
    raddr = '0; rwdata = '0; rf3 = '0; rrdy = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rsp_valid", {31'd0, if2.rsp_valid}, 32'd0);
    check("reset req_ready", {31'd0, if2.req_ready}, 32'd1);
    check("reset busy",      {31'd0, busy2}, 32'd0);
    check("reset rdata",     if2.rsp_rdata, 32'd0);
    check("reset err",       {31'd0, if2.rsp_err}, 32'd0);
    rst_n = 1'b1;

    // Word store/load and latency with two wait states
    txn(D2, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, err, lat);
    check("sw latency", lat, 32'd3);
    check("sw err", {31'd0, err}, 32'd0);
    check("sw rdata", rd, 32'd0);
    txn(D2, 1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
    check("lw 0x10", rd, 32'hDEADBEEF);

    // Byte store and sized/signed loads
    txn(D2, 1'b1, 32'h13, 32'h000000A5, 3'b000, rd, err, lat);
    txn(D2, 1'b0, 32'h13, 32'h0, 3'b000, rd, err, lat);
    check("lb 0x13", rd, 32'hFFFFFFA5);
    txn(D2, 1'b0, 32'h13, 32'h0, 3'b100, rd, err, lat);
    check("lbu 0x13", rd, 32'h000000A5);
    txn(D2, 1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
    check("lw after sb", rd, 32'hA5ADBEEF);
    txn(D2, 1'b0, 32'h12, 32'h0, 3'b001, rd, err, lat);
    check("lh 0x12", rd, 32'hFFFFA5AD);
    txn(D2, 1'b0, 32'h12, 32'h0, 3'b101, rd, err, lat);
    check("lhu 0x12", rd, 32'h0000A5AD);

    // Error cases leave memory untouched
    txn(D2, 1'b0, 32'h11, 32'h0, 3'b001, rd, err, lat);
    check("lh misaligned err", {31'd0, err}, 32'd1);
    check("lh misaligned rdata", rd, 32'd0);
    check("err latency", lat, 32'd3);
    txn(D2, 1'b1, 32'h12, 32'h12345678, 3'b010, rd, err, lat);
    check("sw misaligned err", {31'd0, err}, 32'd1);
    txn(D2, 1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
    check("lw after bad sw", rd, 32'hA5ADBEEF);
    check("lw after bad sw err", {31'd0, err}, 32'd0);
    txn(D2, 1'b0, 32'h10, 32'h0, 3'b011, rd, err, lat);
    check("illegal funct3 err", {31'd0, err}, 32'd1);
    txn(D2, 1'b1, 32'h10, 32'h0, 3'b100, rd, err, lat);
    check("illegal store funct3 err", {31'd0, err}, 32'd1);

    // Halfword store on the upper lanes
    txn(D2, 1'b1, 32'h12, 32'hFFFF7788, 3'b001, rd, err, lat);
    txn(D2, 1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
    check("lw after sh", rd, 32'h7788BEEF);

    // Address range and zero wait states
    txn(D2, 1'b0, 32'h400, 32'h0, 3'b010, rd, err, lat);
    check("lw 0x400 err", {31'd0, err}, 32'd1);
    txn(D2, 1'b1, 32'h3FC, 32'h0BADF00D, 3'b010, rd, err, lat);
    txn(D2, 1'b0, 32'h3FC, 32'h0, 3'b010, rd, err, lat);
    check("lw 0x3FC err", {31'd0, err}, 32'd0);
    check("lw 0x3FC data", rd, 32'h0BADF00D);
    txn(D0, 1'b1, 32'h8, 32'h55AA55AA, 3'b010, rd, err, lat);
    check("w0 sw latency", lat, 32'd1);
    txn(D0, 1'b0, 32'h8, 32'h0, 3'b010, rd, err, lat);
    check("w0 lw latency", lat, 32'd1);
    check("w0 lw data", rd, 32'h55AA55AA);

    // Backpressure with a competing request held during RESP
    rrdy = 1'b0;
    issue(D2, 1'b0, 32'h10, 32'h0, 3'b010);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (if2.rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    check("bp first data", if2.rsp_rdata, 32'h7788BEEF);
    raddr = 32'h3FC; rf3 = 3'b010; rwe = 1'b0; v2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp valid", {31'd0, if2.rsp_valid}, 32'd1);
      check("bp rdata", if2.rsp_rdata, 32'h7788BEEF);
      check("bp err", {31'd0, if2.rsp_err}, 32'd0);
      check("bp req_ready", {31'd0, if2.req_ready}, 32'd0);
    end
    rrdy = 1'b1;
    @(negedge clk);
    check("post-handshake busy", {31'd0, busy2}, 32'd0);
    check("post-handshake req_ready", {31'd0, if2.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    check("held req accepted", {31'd0, busy2}, 32'd1);
    collect(D2, rd, err, lat);
    check("held req data", rd, 32'h0BADF00D);
    check("held req latency", lat, 32'd3);

    // Reset during WAIT discards the store
    txn(D2, 1'b1, 32'h20, 32'h11111111, 3'b010, rd, err, lat);
    txn(D2, 1'b0, 32'h20, 32'h0, 3'b010, rd, err, lat);
    check("lw 0x20 before", rd, 32'h11111111);
    issue(D2, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset valid", {31'd0, if2.rsp_valid}, 32'd0);
    check("mid reset busy", {31'd0, busy2}, 32'd0);
    check("mid reset rdata", if2.rsp_rdata, 32'd0);
    check("mid reset err", {31'd0, if2.rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(D2, 1'b0, 32'h20, 32'h0, 3'b010, rd, err, lat);
    check("lw 0x20 after reset", rd, 32'h11111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
